// File: rtl/dma_pkg.sv
// Shared DMA types and memory-map constants for dma_mem_master and its future
// multi-channel variants.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_STALL,
    ST_WRITE,
    ST_DONE
  } dma_state_t;

  // Highest word a transfer may touch; the word above it is the memory's
  // reserved control/fill word.
  localparam int MEM_LAST_ADDR = 190;
  localparam int MEM_CTRL_ADDR = 191;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

endpackage

// File: rtl/dma_range_chk.sv
// Combinational bound check: ok when base+len-1 <= LAST, evaluated one bit
// wider than the address so the sum never wraps.
module dma_range_chk
  import dma_pkg::*;
#(
  parameter int AW   = 8,
  parameter int LAST = MEM_LAST_ADDR
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic          ok
);

  logic [AW:0] span_end;

  // base+len <= LAST+1 is base+len-1 <= LAST without the underflow at len=0.
  assign span_end = {1'b0, base} + {1'b0, len};
  assign ok       = (span_end <= (AW+1)'(LAST + 1));

endmodule

// File: rtl/dma_mem_master.sv
// Single-channel DMA copy engine owning the shared WR/addr/Data memory bus.
// Optional feature: define DMA_CHECKSUM_EN to add the written-word checksum port.
module dma_mem_master
  import dma_pkg::*;
#(
  parameter int MEM_DEPTH = 192,
  parameter int DW        = 32,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          WR,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] Data,
  input  logic          memfull
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  dma_state_t    state, state_nx;
  logic [AW-1:0] src_q, dst_q, cnt_q;
  logic [AW-1:0] idx, idx_nx;
  logic [AW-1:0] addr_nx;
  logic          wr_nx, err_nx;
  logic [DW-1:0] wbuf;
  logic          src_ok, dst_ok;

  dma_range_chk #(.AW(AW), .LAST(MEM_DEPTH - 2)) u_src_chk (
    .base (src_q),
    .len  (cnt_q),
    .ok   (src_ok)
  );

  dma_range_chk #(.AW(AW), .LAST(MEM_DEPTH - 2)) u_dst_chk (
    .base (dst_q),
    .len  (cnt_q),
    .ok   (dst_ok)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Bus drive enable is the registered WR, so the tristate never sees a
  // combinational path from any input.
  assign Data = (WR == BUS_WR) ? wbuf : {DW{1'bz}};

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped one would infer a latch.
    state_nx = state;
    idx_nx   = idx;
    addr_nx  = addr;
    wr_nx    = BUS_RD;
    err_nx   = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (!(src_ok && dst_ok)) begin
          err_nx   = 1'b1;
          state_nx = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_nx = ST_DONE;
        end else begin
          idx_nx   = '0;
          addr_nx  = src_q;
          state_nx = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: state_nx = ST_RD_DATA;
      ST_RD_DATA, ST_STALL: begin
        if (memfull) begin
          state_nx = ST_STALL;
        end else begin
          wr_nx    = BUS_WR;
          addr_nx  = dst_q + idx;
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_nx = idx + 1'b1;
        if (idx_nx == cnt_q) begin
          state_nx = ST_DONE;
        end else begin
          addr_nx  = src_q + idx_nx;
          state_nx = ST_RD_ADDR;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      WR    <= BUS_RD;
      addr  <= '0;
      err   <= 1'b0;
      wbuf  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      WR    <= wr_nx;
      addr  <= addr_nx;
      err   <= err_nx;
      if (state == ST_IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        cnt_q <= count;
      end
      if (state == ST_RD_DATA) wbuf <= Data;
    end
  end

`ifdef DMA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                    checksum <= '0;
    else if (state == ST_CHECK) checksum <= '0;
    else if (state == ST_WRITE) checksum <= checksum + wbuf;
  end
`endif

  // The range check keeps writes off the reserved control word.
  assert property (@(posedge clk) disable iff (rst)
    !(WR == BUS_WR && addr == AW'(MEM_CTRL_ADDR)));

endmodule

// File: tb/tb_dma_mem_master.sv
// Directed bench for dma_mem_master with a registered-read memory model on the
// shared tristate bus; build with DMA_CHECKSUM_EN to also cover the checksum.
module tb_dma_mem_master;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0, dst = '0, cnt = '0;
  logic          memfull = 1'b0;
  logic          busy, done, err, WR;
  logic [AW-1:0] addr;
  wire  [DW-1:0] Data;
`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  // Memory model: one-cycle read latency, drives Data whenever WR=0.
  logic [DW-1:0] mem [192];
  logic [DW-1:0] rdata = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign Data = WR ? {DW{1'bz}} : rdata;

  always @(posedge clk) begin
    if (ld_en)   mem[ld_a] <= ld_d;
    else if (WR) mem[addr] <= Data;
    rdata <= mem[addr];
  end

  dma_mem_master #(.MEM_DEPTH(192), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src),
    .dst_addr (dst),
    .count    (cnt),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .WR       (WR),
    .addr     (addr),
    .Data     (Data),
    .memfull  (memfull)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
  endtask

  // Runs one request for a fixed window, counting pulses; lat is the cycle
  // (1 = the cycle after start) of the first done or err, -1 if none.
  task automatic run_xfer(input logic [AW-1:0] s, d, c,
                          input int mf_lo, mf_hi, st2_at, rst_at,
                          output int lat, output int n_done, output int n_err,
                          output int n_wr, output int wr_in_stall);
    lat = -1; n_done = 0; n_err = 0; n_wr = 0; wr_in_stall = 0;
    @(negedge clk);
    src = s; dst = d; cnt = c; start = 1'b1;
    for (int n = 1; n <= 3 * int'(c) + 14; n++) begin
      @(negedge clk);
      start   = (n == st2_at);
      memfull = (n >= mf_lo && n <= mf_hi);
      if (st2_at == n) begin src = 8'd0; dst = 8'd100; cnt = 8'd1; end
      if (done) begin n_done++; if (lat < 0) lat = n; end
      if (err)  begin n_err++;  if (lat < 0) lat = n; end
      if (WR) begin
        n_wr++;
        if (n > mf_lo && n <= mf_hi + 1) wr_in_stall++;
      end
      if (n == rst_at + 1) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr", 32'(WR), 32'd0);
        rst = 1'b0;
      end
      if (n == rst_at) rst = 1'b1;
    end
    memfull = 1'b0;
  endtask

  int lat, nd, ne, nw, nws;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_wr", 32'(WR), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
`ifdef DMA_CHECKSUM_EN
    check("reset_checksum", checksum, 32'd0);
`endif

    for (int i = 0; i < 192; i++) load(AW'(i), 32'hA000_0000 | 32'(i));
    load(8'd0, 32'd8);
    load(8'd1, 32'd9);
    load(8'd2, 32'd12);
    @(negedge clk);
    ld_en = 1'b0;

    // Basic copy of three words.
    run_xfer(8'd0, 8'd10, 8'd3, -1, -2, -1, -1, lat, nd, ne, nw, nws);
    check("basic_lat", 32'(lat), 32'd11);
    check("basic_ndone", 32'(nd), 32'd1);
    check("basic_nerr", 32'(ne), 32'd0);
    check("basic_nwr", 32'(nw), 32'd3);
    check("basic_w10", mem[10], 32'd8);
    check("basic_w11", mem[11], 32'd9);
    check("basic_w12", mem[12], 32'd12);
`ifdef DMA_CHECKSUM_EN
    check("basic_checksum", checksum, 32'd29);
`endif

    // Zero-length request.
    run_xfer(8'd0, 8'd0, 8'd0, -1, -2, -1, -1, lat, nd, ne, nw, nws);
    check("zero_lat", 32'(lat), 32'd2);
    check("zero_ndone", 32'(nd), 32'd1);
    check("zero_nwr", 32'(nw), 32'd0);

    // Destination runs onto the control word: rejected.
    run_xfer(8'd0, 8'd189, 8'd3, -1, -2, -1, -1, lat, nd, ne, nw, nws);
    check("rej_lat", 32'(lat), 32'd2);
    check("rej_nerr", 32'(ne), 32'd1);
    check("rej_ndone", 32'(nd), 32'd0);
    check("rej_nwr", 32'(nw), 32'd0);
    check("rej_w189", mem[189], 32'hA000_00BD);
    check("rej_w191", mem[191], 32'hA000_00BF);

    // memfull held over four sampling edges starting at the end of RD_DATA.
    run_xfer(8'd5, 8'd50, 8'd1, 3, 6, -1, -1, lat, nd, ne, nw, nws);
    check("stall_lat", 32'(lat), 32'd9);
    check("stall_wr_during", 32'(nws), 32'd0);
    check("stall_nwr", 32'(nw), 32'd1);
    check("stall_w50", mem[50], 32'hA000_0005);

    // Reset during the second word's WRITE (cycle 7) of a four-word copy.
    run_xfer(8'd60, 8'd70, 8'd4, -1, -2, -1, 7, lat, nd, ne, nw, nws);
    check("rstmid_ndone", 32'(nd), 32'd0);
    check("rstmid_nwr", 32'(nw), 32'd2);
    check("rstmid_w70", mem[70], 32'hA000_003C);
    check("rstmid_w71", mem[71], 32'hA000_003D);
    check("rstmid_w72", mem[72], 32'hA000_0048);

    // Second start while busy must be ignored.
    run_xfer(8'd20, 8'd40, 8'd2, -1, -2, 4, -1, lat, nd, ne, nw, nws);
    check("busy_lat", 32'(lat), 32'd8);
    check("busy_ndone", 32'(nd), 32'd1);
    check("busy_nerr", 32'(ne), 32'd0);
    check("busy_w40", mem[40], 32'hA000_0014);
    check("busy_w41", mem[41], 32'hA000_0015);
    check("busy_w100", mem[100], 32'hA000_0064);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
